// File: rtl/keypad_pkg.sv
// Shared keypad-lab package: segment codes (active-low gfedcba),
// error-pattern glyphs, digit-enable constants and the blink phase type.
package keypad_pkg;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_EH = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;

   localparam logic [3:0] AN_OFF = 4'b1111;

   typedef enum logic {
      PHASE_OFF = 1'b0,
      PHASE_ON  = 1'b1
   } blink_phase_e;

   // Active-low one-hot digit enable for a digit index.
   function automatic logic [3:0] digit_enable(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/keypad_seg7_display_hex_to_seg7.sv
// Purely combinational nibble to active-low 7-segment (gfedcba) decoder.
module hex_to_seg7
   import keypad_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Fixed hex glyph table.
   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_EH;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/keypad_seg7_display.sv
// 4-digit common-anode multiplexed 7-segment driver for the keypad scanner.
// Shows the key buffer as hex (blanking invalid digits) or an "Err" pattern
// while is_wrong is high. Define SEG7_ERR_BLINK_EN to make "Err" blink;
// otherwise it is shown steadily.
module keypad_seg7_display
   import keypad_pkg::*;
#(
   parameter int REFRESH_DIV  = 16,
   parameter int BLINK_FRAMES = 8
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] buffer,
   input  logic [3:0]  valid,
   input  logic        is_wrong,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);

   if (REFRESH_DIV < 2 || REFRESH_DIV > 65535) begin : g_bad_refresh
      $error("REFRESH_DIV out of range 2..65535");
   end
   if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink
      $error("BLINK_FRAMES out of range 1..255");
   end

   logic [15:0] refresh_cnt;
   logic [1:0]  digit_idx;
   logic        digit_wrap;
   logic        frame_end;
   logic [15:0] shadow_buf;
   logic [3:0]  shadow_valid;
   logic [3:0]  cur_nibble;
   logic [6:0]  hex_seg;
   logic        pattern_visible;
   logic [3:0]  an_next;
   logic [6:0]  seg_next;

   assign digit_wrap = (refresh_cnt == REFRESH_LAST);
   assign frame_end  = digit_wrap && (digit_idx == 2'd3);

   // Refresh divider and digit scan index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
      end else if (digit_wrap) begin
         refresh_cnt <= '0;
         digit_idx   <= digit_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 16'd1;
      end
   end

   // Frame-aligned snapshot of the key buffer so a frame never tears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_buf   <= '0;
         shadow_valid <= '0;
      end else if (frame_end) begin
         shadow_buf   <= buffer;
         shadow_valid <= valid;
      end
   end

`ifdef SEG7_ERR_BLINK_EN
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   logic         wrong_d;
   logic         wrong_rise;
   logic [7:0]   blink_cnt;
   blink_phase_e phase;

   assign wrong_rise = is_wrong && !wrong_d;
   // A fresh error is forced visible in the same cycle it is detected.
   assign pattern_visible = wrong_rise || (phase == PHASE_ON);

   // Error-edge detect and frame-counted blink phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrong_d   <= 1'b0;
         blink_cnt <= '0;
         phase     <= PHASE_ON;
      end else begin
         wrong_d <= is_wrong;
         if (wrong_rise) begin
            blink_cnt <= '0;
            phase     <= PHASE_ON;
         end else if (is_wrong && frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= '0;
               phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
               blink_cnt <= blink_cnt + 8'd1;
            end
         end
      end
   end
`else
   assign pattern_visible = 1'b1;
`endif

   assign cur_nibble = shadow_buf[{digit_idx, 2'b00} +: 4];

   hex_to_seg7 u_hex (
      .nibble (cur_nibble),
      .seg    (hex_seg)
   );

   // Select what the current digit should show next cycle.
   always_comb begin
      an_next  = AN_OFF;
      seg_next = SEG_BLANK;
      if (is_wrong) begin
         if (pattern_visible) begin
            an_next = digit_enable(digit_idx);
            case (digit_idx)
               2'd3:    seg_next = SEG_E;
               2'd2:    seg_next = SEG_R;
               2'd1:    seg_next = SEG_R;
               default: seg_next = SEG_BLANK;
            endcase
         end
      end else begin
         an_next  = digit_enable(digit_idx);
         seg_next = shadow_valid[digit_idx] ? hex_seg : SEG_BLANK;
      end
   end

   // Registered pin drivers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= an_next;
         seg <= seg_next;
         dp  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_keypad_seg7_display.sv
// Directed bench for keypad_seg7_display with REFRESH_DIV=4, BLINK_FRAMES=2.
// Output at edge e (counted from reset release) shows digit ((e-1)/4)%4;
// frame boundaries (shadow capture) fall on edges 16, 32, 48, ...
module tb_keypad_seg7_display;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] buffer = 16'h0000;
   logic [3:0]  valid = 4'h0;
   logic        is_wrong = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_checks = 0;
   int n_pass   = 0;
   int e        = 0;

   keypad_seg7_display #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .buffer   (buffer),
      .valid    (valid),
      .is_wrong (is_wrong),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         e++;
      end
   endtask

   // Run n cycles, checking each registered output against the scan position.
   task automatic run(input int n, input logic [6:0] s3, input logic [6:0] s2,
                      input logic [6:0] s1, input logic [6:0] s0,
                      input bit off, input string tag);
      logic [6:0] s [4];
      int d;
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      for (int i = 0; i < n; i++) begin
         cyc(1);
         d = ((e - 1) / 4) % 4;
         if (off) begin
            check($sformatf("%s_e%0d_an", tag, e), {12'h0, an}, 16'h000F);
            check($sformatf("%s_e%0d_seg", tag, e), {9'h0, seg}, 16'h007F);
         end else begin
            check($sformatf("%s_e%0d_an", tag, e), {12'h0, an}, {12'h0, ~(4'b0001 << d)});
            check($sformatf("%s_e%0d_seg", tag, e), {9'h0, seg}, {9'h0, s[d]});
         end
      end
      check($sformatf("%s_dp", tag), {15'h0, dp}, 16'h0001);
   endtask

   initial begin
      // Reset state
      buffer = 16'h1234;
      valid  = 4'hF;
      cyc(2);
      check("rst_an", {12'h0, an}, 16'h000F);
      check("rst_seg", {9'h0, seg}, 16'h007F);
      check("rst_dp", {15'h0, dp}, 16'h0001);
      reset = 1'b0;
      e = 0;

      // Cold start: first frame from empty shadows, then 1234
      run(16, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0, "cold_blank");
      run(16, 7'h79, 7'h24, 7'h30, 7'h19, 1'b0, "hex1234");

      // Partial valid: 00A5 with valid 0011 (captured at edge 48)
      buffer = 16'h00A5;
      valid  = 4'b0011;
      run(16, 7'h79, 7'h24, 7'h30, 7'h19, 1'b0, "hold1234");
      run(16, 7'h7F, 7'h7F, 7'h08, 7'h12, 1'b0, "a5_partial");

      // No tearing: 1111 then 2222 mid-frame
      buffer = 16'h1111;
      valid  = 4'hF;
      run(16, 7'h7F, 7'h7F, 7'h08, 7'h12, 1'b0, "hold_a5");
      run(6, 7'h79, 7'h79, 7'h79, 7'h79, 1'b0, "ones_a");
      buffer = 16'h2222;
      run(10, 7'h79, 7'h79, 7'h79, 7'h79, 1'b0, "ones_b");
      run(16, 7'h24, 7'h24, 7'h24, 7'h24, 1'b0, "twos");

      // Error entry mid-digit (edge 115), frames 1-2 visible
      run(2, 7'h24, 7'h24, 7'h24, 7'h24, 1'b0, "twos_pre");
      is_wrong = 1'b1;
      run(14, 7'h06, 7'h2F, 7'h2F, 7'h7F, 1'b0, "err_f1");
      run(16, 7'h06, 7'h2F, 7'h2F, 7'h7F, 1'b0, "err_f2");
`ifdef SEG7_ERR_BLINK_EN
      run(32, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b1, "err_off_f34");
`else
      run(32, 7'h06, 7'h2F, 7'h2F, 7'h7F, 1'b0, "err_steady_f34");
`endif
      run(16, 7'h06, 7'h2F, 7'h2F, 7'h7F, 1'b0, "err_f5");

      // Error exit mid-digit: next cycle reverts to shadows (2222)
      run(2, 7'h06, 7'h2F, 7'h2F, 7'h7F, 1'b0, "err_f6a");
      is_wrong = 1'b0;
      run(14, 7'h24, 7'h24, 7'h24, 7'h24, 1'b0, "exit_hex");

      // Reset mid-frame during error
      is_wrong = 1'b1;
      run(3, 7'h06, 7'h2F, 7'h2F, 7'h7F, 1'b0, "err_again");
      reset = 1'b1;
      #1;
      check("midrst_an", {12'h0, an}, 16'h000F);
      check("midrst_seg", {9'h0, seg}, 16'h007F);
      check("midrst_dp", {15'h0, dp}, 16'h0001);
      is_wrong = 1'b0;
      buffer   = 16'h1234;
      valid    = 4'hF;
      cyc(2);
      check("midrst_hold_an", {12'h0, an}, 16'h000F);
      check("midrst_hold_seg", {9'h0, seg}, 16'h007F);
      reset = 1'b0;
      e = 0;
      run(16, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0, "warm_blank");
      run(16, 7'h79, 7'h24, 7'h30, 7'h19, 1'b0, "warm_hex1234");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
